inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, address/data width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 pc  in  WIDTH  current fetch address from the PC register.
REQ-005 pc_en  out  1  PC register load enable.
REQ-006 inst_req  out  1  sram-like instruction request.
REQ-007 inst_addr  out  WIDTH  request address.
REQ-008 inst_addr_ok  in  1  address accepted by bus.
REQ-009 inst_data_ok  in  1  read data returned.
REQ-010 inst_rdata  in  WIDTH  returned instruction.
REQ-011 flush  in  1  redirect/exception; discard fetch in progress.
REQ-012 id_ready  in  1  decode accepts if_* this cycle.
REQ-013 if_valid  out  1  if_pc/if_instr/if_adel valid.
REQ-014 if_pc  out  WIDTH  PC of delivered instruction.
REQ-015 if_instr  out  WIDTH  delivered instruction.
REQ-016 if_adel  out  1  fetch address misaligned (pc[1:0]!=0).

Function
REQ-017 States: REQ, WAIT, DISCARD, HOLD; at most one bus transaction outstanding.
REQ-018 inst_req SHALL be 1 only in REQ with flush=0 and pc[1:0]=0; inst_addr SHALL equal pc combinationally.
REQ-019 REQ + inst_addr_ok=1 (request issued): latch pc into req_pc, assert pc_en same cycle, go to WAIT.
REQ-020 REQ + misaligned pc + flush=0: no request; next cycle if_valid=1, if_adel=1, if_pc=pc, if_instr=0; go to HOLD; pc_en=0.
REQ-021 WAIT + inst_data_ok=1 + flush=0: next cycle if_valid=1, if_instr=inst_rdata, if_pc=req_pc, if_adel=0; go to HOLD.
REQ-022 HOLD: if_* SHALL stay stable until id_ready=1; on id_ready=1 clear if_valid next cycle, go to REQ.
REQ-023 pc_en SHALL equal (REQ & inst_req & inst_addr_ok) | flush.
REQ-024 flush has priority over all other events in every state.
REQ-025 flush in REQ: no request that cycle, stay REQ.
REQ-026 flush in WAIT with inst_data_ok=0: go to DISCARD; with inst_data_ok=1: drop data, go to REQ.
REQ-027 DISCARD: inst_req=0; on inst_data_ok=1 drop data, go to REQ; no if_valid produced.
REQ-028 flush in HOLD: if_valid=0 next cycle, go to REQ.
REQ-029 inst_data_ok in REQ or HOLD SHALL be ignored.
REQ-030 Minimum latency: addr_ok cycle N, data_ok cycle N+1 -> if_valid at N+2.

Reset
REQ-031 rst=1 SHALL immediately force state REQ, if_valid=0, if_adel=0, if_pc=0, if_instr=0, req_pc=0; pc_en=0 and inst_req=0 while rst=1.
REQ-032 Reset mid-transaction SHALL abandon it; later inst_data_ok ignored per REQ-029.
REQ-033 First request SHALL issue in the first cycle after rst deasserts, with inst_addr=pc (0xbfc00000 from PC register).

Verification
REQ-034 Basic fetch: pc=0xbfc00000, addr_ok same cycle, data_ok next, rdata=0x24080001, id_ready=1 -> if_valid 1 cycle, if_pc=0xbfc00000, if_instr=0x24080001, pc_en 1 cycle.
REQ-035 Backpressure: id_ready=0 for 5 cycles after delivery -> if_* stable 6 cycles, inst_req=0 throughout, next request after id_ready=1.
REQ-036 Flush in WAIT: flush with data pending, data_ok 3 cycles later rdata=0xdeadbeef -> if_valid never 1 for it; next request addr = redirected pc.
REQ-037 Flush coincident with data_ok in WAIT -> data dropped, state REQ next cycle, pc_en=1 in flush cycle.
REQ-038 Misaligned: pc=0xbfc00002 -> inst_req=0, next cycle if_valid=1, if_adel=1, if_pc=0xbfc00002, if_instr=0.
REQ-039 Async reset asserted in WAIT between clock edges -> if_valid=0 and state REQ without clock edge; stray data_ok afterwards produces no if_valid.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues one sram-like read per PC and holds the
// result for decode. Also handles flush/redirect, misaligned PCs and async reset.
module inst_fetch_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_en,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    input  logic             flush,
    input  logic             id_ready,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             if_adel
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] req_pc;
    logic             misaligned;
    logic             issue;
    logic             deliver_adel;
    logic             deliver_data;
    logic             release_hold;

    assign misaligned = (pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush wins everywhere; a flushed WAIT must still drain its outstanding read.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (flush)           state_nxt = S_REQ;
                else if (misaligned) state_nxt = S_HOLD;
                else if (issue)      state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush)             state_nxt = inst_data_ok ? S_REQ : S_DISCARD;
                else if (inst_data_ok) state_nxt = S_HOLD;
            end
            S_DISCARD: begin
                if (inst_data_ok) state_nxt = S_REQ;
            end
            S_HOLD: begin
                if (flush || id_ready) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        inst_req     = ~rst && (state == S_REQ) && ~flush && ~misaligned;
        issue        = inst_req && inst_addr_ok;
        pc_en        = ~rst && (issue || flush);
        deliver_adel = (state == S_REQ) && ~flush && misaligned;
        deliver_data = (state == S_WAIT) && ~flush && inst_data_ok;
        release_hold = (state == S_HOLD) && (flush || id_ready);
    end

    assign inst_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc   <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
            if_adel  <= 1'b0;
        end else begin
            if (issue) begin
                req_pc <= pc;
            end
            if (deliver_adel) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= '0;
                if_adel  <= 1'b1;
            end else if (deliver_data) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_instr <= inst_rdata;
                if_adel  <= 1'b0;
            end else if (release_hold) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: reset, basic fetch, backpressure, flush cases,
// misaligned PC and asynchronous reset mid-transaction.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        flush;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .flush(flush), .id_ready(id_ready),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_adel(if_adel)
    );

    // Inputs change 2 time units after a rising edge; checks happen 1 unit later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'hbfc00000; inst_addr_ok = 1'b1; inst_data_ok = 1'b0;
        inst_rdata = '0; flush = 1'b0; id_ready = 1'b0;
        #3;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL rst_inst_req got=%0b exp=0", inst_req); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rst_pc_en got=%0b exp=0", pc_en); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%0b exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_if_pc got=%08h exp=00000000", if_pc); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_if_instr got=%08h exp=00000000", if_instr); end
        checks++; if (if_adel !== 1'b0) begin failures++; $display("FAIL rst_if_adel got=%0b exp=0", if_adel); end
        step();
        step();
        inst_addr_ok = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", inst_req); end
        checks++; if (inst_addr !== 32'hbfc00000) begin failures++; $display("FAIL first_addr got=%08h exp=bfc00000", inst_addr); end
    endtask

    task automatic test_basic_fetch();
        pc = 32'hbfc00000; inst_addr_ok = 1'b1; id_ready = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL basic_pc_en_issue got=%0b exp=1", pc_en); end
        step();
        pc = 32'hbfc00004; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24080001;
        #1;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL basic_wait_req got=%0b exp=0", inst_req); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL basic_wait_pc_en got=%0b exp=0", pc_en); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL basic_wait_valid got=%0b exp=0", if_valid); end
        step();
        inst_data_ok = 1'b0; inst_rdata = 32'h0;
        #1;
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", if_valid); end
        checks++; if (if_pc !== 32'hbfc00000) begin failures++; $display("FAIL basic_if_pc got=%08h exp=bfc00000", if_pc); end
        checks++; if (if_instr !== 32'h24080001) begin failures++; $display("FAIL basic_if_instr got=%08h exp=24080001", if_instr); end
        checks++; if (if_adel !== 1'b0) begin failures++; $display("FAIL basic_if_adel got=%0b exp=0", if_adel); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL basic_hold_pc_en got=%0b exp=0", pc_en); end
        step();
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_clear got=%0b exp=0", if_valid); end
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL basic_next_req got=%0b exp=1", inst_req); end
        checks++; if (inst_addr !== 32'hbfc00004) begin failures++; $display("FAIL basic_next_addr got=%08h exp=bfc00004", inst_addr); end
    endtask

    task automatic test_backpressure();
        pc = 32'hbfc00004; inst_addr_ok = 1'b1; id_ready = 1'b0;
        step();
        pc = 32'hbfc00008; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8c020000;
        step();
        inst_data_ok = 1'b1; inst_rdata = 32'h12345678;
        for (int i = 0; i < 6; i++) begin
            id_ready = (i == 5);
            #1;
            checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, if_valid); end
            checks++; if (if_pc !== 32'hbfc00004) begin failures++; $display("FAIL bp_if_pc[%0d] got=%08h exp=bfc00004", i, if_pc); end
            checks++; if (if_instr !== 32'h8c020000) begin failures++; $display("FAIL bp_if_instr[%0d] got=%08h exp=8c020000", i, if_instr); end
            checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL bp_req[%0d] got=%0b exp=0", i, inst_req); end
            step();
        end
        inst_data_ok = 1'b0; id_ready = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_clear got=%0b exp=0", if_valid); end
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL bp_next_req got=%0b exp=1", inst_req); end
    endtask

    task automatic test_flush_wait();
        pc = 32'hbfc00008; inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; flush = 1'b1; pc = 32'h80000180;
        #1;
        checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL fw_pc_en got=%0b exp=1", pc_en); end
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL fw_req_flush got=%0b exp=0", inst_req); end
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inst_data_ok = (i == 2);
            inst_rdata = (i == 2) ? 32'hdeadbeef : 32'h0;
            #1;
            checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL fw_discard_req[%0d] got=%0b exp=0", i, inst_req); end
            checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fw_discard_valid[%0d] got=%0b exp=0", i, if_valid); end
            step();
        end
        inst_data_ok = 1'b0; inst_rdata = 32'h0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fw_after_valid got=%0b exp=0", if_valid); end
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL fw_after_req got=%0b exp=1", inst_req); end
        checks++; if (inst_addr !== 32'h80000180) begin failures++; $display("FAIL fw_redirect_addr got=%08h exp=80000180", inst_addr); end
        step();
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fw_late_valid got=%0b exp=0", if_valid); end
    endtask

    task automatic test_flush_data_ok();
        pc = 32'h80000180; inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0; flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h11111111; pc = 32'h80000200;
        #1;
        checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL fd_pc_en got=%0b exp=1", pc_en); end
        step();
        flush = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL fd_valid got=%0b exp=0", if_valid); end
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL fd_req_state got=%0b exp=1", inst_req); end
        checks++; if (inst_addr !== 32'h80000200) begin failures++; $display("FAIL fd_addr got=%08h exp=80000200", inst_addr); end
    endtask

    task automatic test_misaligned();
        pc = 32'hbfc00002; inst_addr_ok = 1'b1; id_ready = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%0b exp=0", inst_req); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL mis_pc_en got=%0b exp=0", pc_en); end
        step();
        inst_addr_ok = 1'b0; id_ready = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL mis_valid got=%0b exp=1", if_valid); end
        checks++; if (if_adel !== 1'b1) begin failures++; $display("FAIL mis_adel got=%0b exp=1", if_adel); end
        checks++; if (if_pc !== 32'hbfc00002) begin failures++; $display("FAIL mis_if_pc got=%08h exp=bfc00002", if_pc); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL mis_if_instr got=%08h exp=00000000", if_instr); end
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL mis_hold_req got=%0b exp=0", inst_req); end
        step();
        pc = 32'hbfc00000;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mis_valid_clear got=%0b exp=0", if_valid); end
    endtask

    task automatic test_async_reset();
        pc = 32'hbfc00000; inst_addr_ok = 1'b1; id_ready = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b0) begin failures++; $display("FAIL ar_wait_req got=%0b exp=0", inst_req); end
        rst = 1'b1;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0b exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL ar_if_pc got=%08h exp=00000000", if_pc); end
        checks++; if (if_adel !== 1'b0) begin failures++; $display("FAIL ar_if_adel got=%0b exp=0", if_adel); end
        checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL ar_pc_en got=%0b exp=0", pc_en); end
        #1;
        rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hcafef00d;
        #1;
        checks++; if (inst_req !== 1'b1) begin failures++; $display("FAIL ar_state_req got=%0b exp=1", inst_req); end
        step();
        inst_data_ok = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL ar_stray_valid got=%0b exp=0", if_valid); end
        step();
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL ar_stray_valid2 got=%0b exp=0", if_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_flush_wait();
        test_flush_data_ok();
        test_misaligned();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
